// File: rtl/crossing_sequencer.sv
// Two-track level-crossing sequencer: road warning, gate lowering, round-robin track grant, gate raising.
// Optional post-raise minimum road-green (HOLD state) enabled by defining CROSS_MIN_GREEN_EN.
module crossing_sequencer #(
    parameter int YELLOW_CYC = 3,
    parameter int GATE_CYC   = 4,
    parameter int MIN_GREEN  = 5,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req_a,
    input  logic       req_b,
    output logic [1:0] road,
    output logic [1:0] track_a,
    output logic [1:0] track_b,
    output logic       gate_down,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARN,
        ST_LOWER,
        ST_GRANT,
        ST_SWAP,
        ST_RAISE,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [1:0] road;
        logic [1:0] track_a;
        logic [1:0] track_b;
        logic       gate_down;
        logic       busy;
    } outs_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] YELLOW_LD  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LD    = CNT_W'(GATE_CYC - 1);
`ifdef CROSS_MIN_GREEN_EN
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(MIN_GREEN - 1);
`endif

    if (YELLOW_CYC < 1 || GATE_CYC < 1 || MIN_GREEN < 1 ||
        YELLOW_CYC >= (1 << CNT_W) || GATE_CYC >= (1 << CNT_W) ||
        MIN_GREEN >= (1 << CNT_W)) begin : g_param_check
        $error("crossing_sequencer: cycle parameters must be >= 1 and fit in CNT_W bits");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    outs_t            out_q;
    logic [1:0]       req_vec;

    assign req_vec = {req_b, req_a};

    function automatic outs_t decode(input state_e st, input logic g);
        outs_t o;
        o      = '0;
        o.busy = 1'b1;
        case (st)
            ST_IDLE: begin
                o.road = 2'b10;
                o.busy = 1'b0;
            end
            ST_WARN:            o.road = 2'b01;
            ST_LOWER, ST_SWAP:  o.gate_down = 1'b1;
            ST_GRANT: begin
                o.gate_down = 1'b1;
                if (g) o.track_b = 2'b10;
                else   o.track_a = 2'b10;
            end
            ST_HOLD:            o.road = 2'b10;
            default: ;
        endcase
        return o;
    endfunction

    // NOTE: every next-state signal gets a default before the case, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - ONE : cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: if (req_a || req_b) begin
                state_d = ST_WARN;
                cnt_d   = YELLOW_LD;
            end
            ST_WARN: if (cnt_q == '0) begin
                state_d = ST_LOWER;
                cnt_d   = GATE_LD;
            end
            ST_LOWER: if (cnt_q == '0) begin
                if (req_a && req_b) begin
                    state_d = ST_GRANT;
                    gnt_d   = ~last_q;
                end else if (req_a || req_b) begin
                    state_d = ST_GRANT;
                    gnt_d   = req_b;
                end else begin
                    state_d = ST_RAISE;
                    cnt_d   = GATE_LD;
                end
            end
            ST_GRANT: if (!req_vec[gnt_q]) begin
                last_d  = gnt_q;
                state_d = ST_SWAP;
            end
            // Handover to the waiting track keeps the gate down; otherwise raise.
            ST_SWAP: if (req_vec[~gnt_q]) begin
                state_d = ST_GRANT;
                gnt_d   = ~gnt_q;
            end else begin
                state_d = ST_RAISE;
                cnt_d   = GATE_LD;
            end
            ST_RAISE: if (cnt_q == '0) begin
`ifdef CROSS_MIN_GREEN_EN
                state_d = ST_HOLD;
                cnt_d   = HOLD_LD;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef CROSS_MIN_GREEN_EN
            ST_HOLD: if (cnt_q == '0) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so they track state_q exactly.
    // NOTE: sequential state uses non-blocking assignments only, avoiding ordering races between flops.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            out_q   <= decode(ST_IDLE, 1'b0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            out_q   <= decode(state_d, gnt_d);
        end
    end

    assign road      = out_q.road;
    assign track_a   = out_q.track_a;
    assign track_b   = out_q.track_b;
    assign gate_down = out_q.gate_down;
    assign busy      = out_q.busy;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Bench for crossing_sequencer: timeline reference model of the closure sequence, directed
// scenarios followed by random requests/resets; honours CROSS_MIN_GREEN_EN like the design.
module tb_crossing_sequencer;

    localparam int YELLOW_CYC = 3;
    localparam int GATE_CYC   = 4;
    localparam int MIN_GREEN  = 5;
    localparam int CNT_W      = 4;

    // Packed as {road, track_a, track_b, gate_down, busy}.
    localparam logic [7:0] O_IDLE  = 8'b10_00_00_0_0;
    localparam logic [7:0] O_WARN  = 8'b01_00_00_0_1;
    localparam logic [7:0] O_LOWER = 8'b00_00_00_1_1;
    localparam logic [7:0] O_SWAP  = 8'b00_00_00_1_1;
    localparam logic [7:0] O_RAISE = 8'b00_00_00_0_1;
    localparam logic [7:0] O_HOLD  = 8'b10_00_00_0_1;

    logic       clk = 1'b0;
    logic       clr, req_a, req_b;
    logic [1:0] road, track_a, track_b;
    logic       gate_down, busy;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_out  = O_IDLE;
    bit         chk_en   = 1'b0;
    bit         s_clr, s_a, s_b;
    bit         last_b   = 1'b1;

    crossing_sequencer #(
        .YELLOW_CYC(YELLOW_CYC),
        .GATE_CYC  (GATE_CYC),
        .MIN_GREEN (MIN_GREEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .req_a    (req_a),
        .req_b    (req_b),
        .road     (road),
        .track_a  (track_a),
        .track_b  (track_b),
        .gate_down(gate_down),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] o_grant(input bit g);
        return g ? 8'b00_00_10_1_1 : 8'b00_10_00_1_1;
    endfunction

    task automatic tick();
        @(posedge clk);
        s_clr = clr;
        s_a   = req_a;
        s_b   = req_b;
    endtask

    // Stays in the current phase for n edges; the inputs seen on the last edge decide what follows.
    task automatic hold(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (s_clr) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // Reference model: walks the closure sequence as a timeline of phase durations.
    initial begin : model
        bit ab, g, have, other_req;
        forever begin
            exp_out = O_IDLE;
            do begin
                tick();
                if (s_clr) last_b = 1'b1;
            end while (s_clr || !(s_a || s_b));

            exp_out = O_WARN;
            hold(YELLOW_CYC, ab);
            if (ab) begin last_b = 1'b1; continue; end

            exp_out = O_LOWER;
            hold(GATE_CYC, ab);
            if (ab) begin last_b = 1'b1; continue; end

            have = s_a || s_b;
            g    = (s_a && s_b) ? !last_b : s_b;
            while (have) begin
                exp_out = o_grant(g);
                do hold(1, ab); while (!ab && (g ? s_b : s_a));
                if (ab) break;
                last_b  = g;
                exp_out = O_SWAP;
                hold(1, ab);
                if (ab) break;
                other_req = g ? s_a : s_b;
                if (other_req) g = !g;
                else           have = 1'b0;
            end
            if (ab) begin last_b = 1'b1; continue; end

            exp_out = O_RAISE;
            hold(GATE_CYC, ab);
            if (ab) begin last_b = 1'b1; continue; end
`ifdef CROSS_MIN_GREEN_EN
            exp_out = O_HOLD;
            hold(MIN_GREEN, ab);
            if (ab) begin last_b = 1'b1; continue; end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("outputs", {road, track_a, track_b, gate_down, busy}, exp_out);
            check("inv_exclusive", (track_a == 2'b10 && track_b == 2'b10), 0);
            check("inv_no_01", (track_a == 2'b01 || track_b == 2'b01), 0);
            if (track_a == 2'b10 || track_b == 2'b10)
                check("inv_grant_closed", {road, gate_down}, 3'b001);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clr   = 1'b1;
        req_a = 1'b1;
        req_b = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset held with a pending request, then a single train on A.
        cyc(5);
        clr = 1'b0;
        cyc(20);
        req_a = 1'b0;
        cyc(10);

        // Tie: A first, one all-red cycle, then B; a second tie goes to A again.
        req_a = 1'b1; req_b = 1'b1;
        cyc(12);
        req_a = 1'b0;
        cyc(6);
        req_b = 1'b0;
        cyc(10);
        req_a = 1'b1; req_b = 1'b1;
        cyc(12);
        req_a = 1'b0; req_b = 1'b0;
        cyc(12);

        // Request withdrawn during WARN.
        req_b = 1'b1;
        cyc(2);
        req_b = 1'b0;
        cyc(15);

        // Reset while B holds the crossing, then a tie.
        req_b = 1'b1;
        cyc(12);
        clr = 1'b1; req_b = 1'b0;
        cyc(1);
        clr = 1'b0;
        cyc(2);
        req_a = 1'b1; req_b = 1'b1;
        cyc(12);
        req_a = 1'b0; req_b = 1'b0;
        cyc(12);

        // A re-requests as the gate finishes rising.
        req_a = 1'b1;
        cyc(12);
        req_a = 1'b0;
        cyc(5);
        req_a = 1'b1;
        cyc(20);
        req_a = 1'b0;
        cyc(15);

        // Random request levels with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) req_a = ~req_a;
            if ($urandom_range(0, 9) == 0) req_b = ~req_b;
            clr = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        clr = 1'b0; req_a = 1'b0; req_b = 1'b0;
        cyc(25);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crossing_sequencer.md
# crossing_sequencer

Sequencer that shares one road/rail level crossing between two approach tracks (A, B). It runs the full closure sequence: road warning, gate lowering, track clearance, gate raising. It arbitrates round-robin when both tracks request. The block sits above the single-track gate controller and drives the road signal, both track signals and the gate motor command.

## Interface
- `YELLOW_CYC`, 3: cycles the road signal shows yellow before going red.
- `GATE_CYC`, 4: gate travel time in cycles, used for both lowering and raising.
- `MIN_GREEN`, 5: minimum road-green cycles after a raise (only with `CROSS_MIN_GREEN_EN`).
- `CNT_W`, 4: width of the shared down-counter; must hold max(`YELLOW_CYC`, `GATE_CYC`, `MIN_GREEN`).
- `clk`  in  1: single clock; all state changes on the rising edge.
- `clr`  in  1: reset, synchronous, active-high.
- `req_a`  in  1: train present on approach/crossing zone of track A. Level signal, held until the train has cleared.
- `req_b`  in  1: same as `req_a`, for track B.
- `road`  out  2: road signal; 2'b10 green, 2'b01 yellow, 2'b00 red.
- `track_a`  out  2: track A signal; 2'b10 proceed, 2'b00 stop. 2'b01 is never driven.
- `track_b`  out  2: track B signal; same encoding as `track_a`.
- `gate_down`  out  1: gate motor command; 1 = lower/hold down, 0 = raise/hold up.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Outputs are a Moore decode of the registered state and the grant register. There is no combinational path from inputs to outputs.
- Registers: state, `cnt` (CNT_W bits), `gnt` (0 = A, 1 = B), `last` (last served track).
- IDLE: road=10, tracks=00, gate_down=0.
  - Any request → WARN; cnt loads YELLOW_CYC-1.
- WARN: road=01, gate_down=0. When cnt=0 → LOWER; cnt loads GATE_CYC-1.
- LOWER: road=00, gate_down=1. When cnt=0, arbitrate on the current requests:
  - If only one is high, grant it.
  - If both are high, grant the track ≠ `last`.
  - If neither is high (request withdrawn), go to RAISE with no grant.
- GRANT: road=00, gate_down=1; granted track=10, other track=00.
  - Stays while the granted request is high.
  - When the granted request falls: `last`←`gnt`, then → SWAP.
- SWAP: one all-red cycle; both tracks=00, gate_down=1.
  - If the other track's request is high, grant it and go to GRANT; the gate stays down.
  - Otherwise → RAISE; cnt loads GATE_CYC-1.
- RAISE: road=00, tracks=00, gate_down=0. When cnt=0 → IDLE (or HOLD when the macro is enabled).
- Safety invariants, asserted in the bench:
  - A track is 10 only in GRANT.
  - In GRANT, road=00 and gate_down=1.
  - track_a and track_b are never 10 together.
- Requests arriving during WARN, LOWER or RAISE are not latched. They are sampled at the LOWER exit, in SWAP, or in IDLE.
- Counter decrements by 1 per cycle and never wraps. A parameter value of 1 gives a single-cycle state.
- Reset (any state, any cycle): next edge gives IDLE, cnt=0, gnt=0, last=B (so A wins the first tie). Outputs become road=10, tracks=00, gate_down=0, busy=0.

## Timing
- With a request high at edge k in IDLE:
  - WARN covers edges k+1..k+YELLOW_CYC.
  - LOWER covers the next GATE_CYC cycles.
  - Track goes green at edge k+1+YELLOW_CYC+GATE_CYC (k+8 with defaults).
- When the granted request falls before edge m: SWAP at m, then the other track is green at m+1, or RAISE occupies m+1..m+GATE_CYC and IDLE follows at m+GATE_CYC+1.
- A track-to-track handover always has exactly one all-red cycle and never raises the gate.

## Configuration
- `CROSS_MIN_GREEN_EN` defined:
  - RAISE exits to HOLD (road=10, tracks=00, gate_down=0, busy=1), with cnt loaded MIN_GREEN-1.
  - HOLD ignores requests until cnt=0, then → IDLE.
  - After reset, IDLE is entered directly (no HOLD).
- Undefined: HOLD does not exist; RAISE → IDLE, and a request may start WARN on the next edge.

## Test plan
- Reset: clr high for 5 cycles with req_a=1 → road=10, track_a=track_b=00, gate_down=0, busy=0 throughout; WARN starts on the first edge after clr falls.
- Single train: req_a high for 20 cycles (defaults) → road 01 for 3 cycles, then 00 with gate_down=1 for 4 cycles, then track_a=10 until req_a falls. Then 1 SWAP cycle, 4 RAISE cycles, road=10.
- Tie: req_a and req_b rise together → track_a green first. After req_a falls, 1 all-red cycle, then track_b=10 with gate_down held at 1. A new tie afterwards grants A again (last=B).
- Withdrawn request: req_b high 2 cycles during WARN only → no track ever 10; RAISE for 4 cycles; road=10 at LOWER exit + 5.
- Reset mid-operation: clr pulsed 1 cycle while track_b=10 → next edge road=10, track_b=00, gate_down=0; a following tie grants A.
- `CROSS_MIN_GREEN_EN`: req_a reasserted on the first IDLE-bound cycle → road stays 10 for 5 cycles before WARN; without the macro, WARN follows on the next edge.
